// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - sliced multi-function bitwise logic unit with zero/negative flags
module bitwise_logic_unit #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zacc;
  logic             r_zero;
  logic             r_neg;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_sr;
  logic             w_szero;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // in_ready is also gated by reset_n so nothing is accepted while held in reset
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = reset_n;
        if (in_valid && reset_n) w_next = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sa = r_a[int'(r_cnt)*SLICE +: SLICE];
    w_sb = r_b[int'(r_cnt)*SLICE +: SLICE];
    case (r_op)
      3'b000:  w_sr = w_sa & w_sb;
      3'b001:  w_sr = w_sa | w_sb;
      3'b010:  w_sr = w_sa ^ w_sb;
      3'b011:  w_sr = ~(w_sa & w_sb);
      3'b100:  w_sr = ~(w_sa | w_sb);
      3'b101:  w_sr = ~(w_sa ^ w_sb);
      3'b110:  w_sr = w_sa & ~w_sb;
      default: w_sr = w_sa;
    endcase
    w_szero = (w_sr == '0);
  end

  // The counter holds at the last slice instead of wrapping; accept re-arms it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zacc   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_op     <= op;
      r_cnt    <= '0;
      r_result <= '0;
      r_zacc   <= 1'b1;
    end else if (r_state == S_BUSY) begin
      r_result[int'(r_cnt)*SLICE +: SLICE] <= w_sr;
      r_zacc <= r_zacc & w_szero;
      if (w_last) begin
        r_zero <= r_zacc & w_szero;
        r_neg  <= w_sr[SLICE-1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign negative = r_neg;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - self-checking bench for bitwise_logic_unit
module tb_bitwise_logic_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        m_in_valid = 0, m_in_ready, m_out_valid, m_out_ready = 0;
  logic [63:0] m_a = 0, m_b = 0, m_result;
  logic [2:0]  m_op = 0;
  logic        m_zero, m_neg, m_busy;

  logic        w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 0;
  logic [31:0] w_a = 0, w_b = 0, w_result;
  logic [2:0]  w_op = 0;
  logic        w_zero, w_neg, w_busy;

  logic        s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
  logic [63:0] s_a = 0, s_b = 0, s_result;
  logic [2:0]  s_op = 0;
  logic        s_zero, s_neg, s_busy;

  bitwise_logic_unit #(.WIDTH(64), .SLICE(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .op(m_op), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .result(m_result), .zero(m_zero), .negative(m_neg), .busy(m_busy));

  bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) u_w32 (
    .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_result), .zero(w_zero), .negative(w_neg), .busy(w_busy));

  bitwise_logic_unit #(.WIDTH(64), .SLICE(8)) u_s8 (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .zero(s_zero), .negative(s_neg), .busy(s_busy));

  function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    case (f)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected results pushed at accept, retired at output handshake
  logic [63:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (m_out_valid && m_out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_in_valid && m_in_ready) exp_q.push_back(model(m_op, m_a, m_b));
    end
  end

  always @(negedge clk) begin
    if (reset_n && m_out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        chk("cmp_result", m_result, exp_q[0]);
        chk("cmp_zero", {63'd0, m_zero}, {63'd0, exp_q[0] == 64'd0});
        chk("cmp_negative", {63'd0, m_neg}, {63'd0, exp_q[0][63]});
        chk("cmp_busy_done", {63'd0, m_busy}, 64'd1);
        chk("cmp_in_ready_done", {63'd0, m_in_ready}, 64'd0);
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y,
                       input int stall, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!m_in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!m_in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    m_in_valid = 1'b1; m_a = x; m_b = y; m_op = f;
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 40) begin
      m_a = {$urandom, $urandom};
      m_b = {$urandom, $urandom};
      m_op = 3'($urandom);
      m_in_valid = ~m_in_valid;
      @(posedge clk);
      #1;
      lat++;
    end
    m_in_valid = 1'b0;
    if (!m_out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    repeat (stall) begin
      chk("stall_in_ready", {63'd0, m_in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, m_out_valid}, 64'd1);
      m_a = {$urandom, $urandom};
      m_b = ~m_b;
      m_in_valid = ~m_in_valid;
      @(posedge clk);
      #1;
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_out_ready = 1'b0;
    chk("post_hs_out_valid", {63'd0, m_out_valid}, 64'd0);
    chk("post_hs_in_ready", {63'd0, m_in_ready}, 64'd1);
  endtask

  localparam logic [63:0] TA = 64'hF0F0_0000_FFFF_1234;
  localparam logic [63:0] TB = 64'hFF00_FFFF_0F0F_1234;
  logic [63:0] tbl [8];

  initial begin
    int lat;
    int bad;
    tbl[0] = 64'hF000_0000_0F0F_1234;
    tbl[1] = 64'hFFF0_FFFF_FFFF_1234;
    tbl[2] = 64'h0FF0_FFFF_F0F0_0000;
    tbl[3] = 64'h0FFF_FFFF_F0F0_EDCB;
    tbl[4] = 64'h000F_0000_0000_EDCB;
    tbl[5] = 64'hF00F_0000_0F0F_FFFF;
    tbl[6] = 64'h00F0_0000_F0F0_0000;
    tbl[7] = TA;

    #2;
    chk("rst_out_valid", {63'd0, m_out_valid}, 64'd0);
    chk("rst_busy", {63'd0, m_busy}, 64'd0);
    chk("rst_result", m_result, 64'd0);
    chk("rst_zero", {63'd0, m_zero}, 64'd0);
    chk("rst_negative", {63'd0, m_neg}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, m_in_ready}, 64'd1);

    for (int i = 0; i < 8; i++) chk("model_pin", model(3'(i), TA, TB), tbl[i]);

    do_op(3'd0, 64'h1010101010101010, 64'h0101010101010101, 0, lat);
    chk("and_latency", 64'(lat), 64'd4);
    chk("and_result", m_result, 64'd0);
    chk("and_zero", {63'd0, m_zero}, 64'd1);
    chk("and_negative", {63'd0, m_neg}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(3'(i), TA, TB, 0, lat);
      chk("op_result", m_result, tbl[i]);
      chk("op_negative", {63'd0, m_neg}, {63'd0, tbl[i][63]});
      chk("op_latency", 64'(lat), 64'd4);
    end

    do_op(3'd2, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001, 10, lat);
    chk("bp_result", m_result, 64'h8000_0000_0000_0000);
    chk("bp_negative", {63'd0, m_neg}, 64'd1);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    m_in_valid = 1'b1; m_a = '1; m_b = '1; m_op = 3'd0;
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rstmid_out_valid", {63'd0, m_out_valid}, 64'd0);
    chk("rstmid_busy", {63'd0, m_busy}, 64'd0);
    chk("rstmid_result", m_result, 64'd0);
    chk("rstmid_zero", {63'd0, m_zero}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rstmid_in_ready", {63'd0, m_in_ready}, 64'd1);
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (m_out_valid) bad++;
    end
    chk("rstmid_no_out_valid", 64'(bad), 64'd0);

    @(negedge clk);
    w_in_valid = 1'b1; w_a = '0; w_b = '0; w_op = 3'd1;
    s_in_valid = 1'b1; s_a = '0; s_b = '0; s_op = 3'd1;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    s_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w32_latency", 64'(lat), 64'd1);
    chk("w32_result", {32'd0, w_result}, 64'd0);
    chk("w32_zero", {63'd0, w_zero}, 64'd1);
    while (!s_out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("s8_latency", 64'(lat), 64'd8);
    chk("s8_result", s_result, 64'd0);
    chk("s8_zero", {63'd0, s_zero}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
